// File: rtl/rom_uart_seq.sv
// Streams a byte string out of a synchronous ROM into uart_tx, one byte per
// idle-transmitter window, with optional NUL termination and abort.
module rom_uart_seq #(
    parameter int ADDR_W      = 10,
    parameter int LEN_W       = 10,
    parameter int ROM_LAT     = 1,
    parameter int STOP_ON_NUL = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [LEN_W-1:0]  i_len,
    input  logic              i_abort,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [7:0]        i_rom_q,
    output logic [7:0]        o_tx_data,
    output logic              o_tx_vld,
    input  logic              i_tx_busy,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CHECK,
        S_SEND,
        S_GUARD,
        S_DONE
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(ROM_LAT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        lat_q, lat_d;
    logic              send;

    // NOTE: every signal written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        count_d  = count_q;
        data_d   = data_q;
        lat_d    = '0;
        send     = 1'b0;

        if (i_abort && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        remain_d = i_len;
                        count_d  = '0;
                        // An empty string leaves the ROM address untouched.
                        if (i_len == '0) begin
                            state_d = S_DONE;
                        end else begin
                            addr_d  = i_base;
                            state_d = S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (lat_q == LAT_LAST) begin
                        state_d = S_CHECK;
                    end else begin
                        lat_d = lat_q + 2'd1;
                    end
                end
                S_CHECK: begin
                    if (STOP_ON_NUL != 0 && i_rom_q == 8'h00) begin
                        state_d = S_DONE;
                    end else begin
                        data_d  = i_rom_q;
                        state_d = S_SEND;
                    end
                end
                S_SEND: begin
                    if (!i_tx_busy) begin
                        send     = 1'b1;
                        count_d  = count_q + 1'b1;
                        remain_d = remain_q - 1'b1;
                        addr_d   = addr_q + 1'b1;
                        state_d  = S_GUARD;
                    end
                end
                // uart_tx raises busy a cycle late; skip looking at it once.
                S_GUARD: begin
                    state_d = (remain_q == '0) ? S_DONE : S_FETCH;
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            count_q  <= '0;
            data_q   <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            data_q   <= data_d;
            lat_q    <= lat_d;
        end
    end

    assign o_rom_addr = addr_q;
    assign o_tx_data  = data_q;
    assign o_tx_vld   = send;
    assign o_busy     = (state_q != S_IDLE);
    assign o_done     = (state_q == S_DONE) && !i_abort;
    assign o_count    = count_q;

endmodule
